// File: rtl/cpl_r_channel_maker_pkg.sv
`default_nettype none
// PCIe completion decode helpers and AXI R-channel constants shared by the completion path.
package PCIE_PKG;

  localparam int ID_WIDTH = 4;

  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;
  localparam logic [2:0] CPL_CA = 3'b100;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR  = 2'd2
  } cpl_state_t;

  typedef struct packed {
    logic [7:0]  tag;
    logic [2:0]  status;
    logic [9:0]  length;
    logic [11:0] byte_count;
  } cpl_hdr_t;

  function automatic cpl_hdr_t decode_cpl_header(input logic [127:0] hdr);
    cpl_hdr_t h;
    h.length     = hdr[9:0];
    h.status     = hdr[47:45];
    h.byte_count = hdr[43:32];
    h.tag        = hdr[79:72];
    return h;
  endfunction

  // 8 DW per beat; a zero length field encodes 1024 DW, i.e. 128 beats.
  function automatic logic [7:0] data_beats(input logic [9:0] length);
    if (length == 10'd0)
      return 8'd128;
    return {1'b0, length[9:3]} + {7'd0, |length[2:0]};
  endfunction

  // 32 bytes per beat; a zero byte_count encodes 4096 bytes, i.e. 128 beats.
  function automatic logic [7:0] err_beats(input logic [11:0] byte_count);
    if (byte_count == 12'd0)
      return 8'd128;
    return {1'b0, byte_count[11:5]} + {7'd0, |byte_count[4:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpl_r_channel_maker_if.sv
`default_nettype none
// AXI4 read-data channel bundle; master drives the beat, slave drives rready.
interface AXI4_R_IF #(
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = PCIE_PKG::ID_WIDTH
);
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (output rid, rdata, rresp, rlast, rvalid, input rready);
  modport slave  (input rid, rdata, rresp, rlast, rvalid, output rready);
endinterface
`default_nettype wire

// File: rtl/cpl_r_channel_maker.sv
`default_nettype none
// cpl_r_channel_maker: turns PCIe completion header/payload FIFOs into AXI4 R beats.
// Non-SC completions yield SLVERR beats sized from byte_count and leave their payload in the FIFO.
module cpl_r_channel_maker
  import PCIE_PKG::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = PCIE_PKG::ID_WIDTH
) (
  input  wire                  clk,
  input  wire                  rst,
  input  wire                  cpl_hdr_empty,
  input  wire [127:0]          cpl_hdr_data,
  output logic                 cpl_hdr_rden,
  input  wire                  cpl_data_empty,
  input  wire [DATA_WIDTH-1:0] cpl_data_data,
  output logic                 cpl_data_rden,
  AXI4_R_IF.master             r_if
);

  cpl_state_t          state;
  cpl_state_t          next_state;
  cpl_hdr_t            hdr;
  logic [7:0]          cnt;
  logic [ID_WIDTH-1:0] cpl_id;
  logic                settle;
  logic                load;
  logic                out_free;
  logic                last_beat;
  logic [7:0]          tag_unused;

  assign hdr        = decode_cpl_header(cpl_hdr_data);
  assign tag_unused = hdr.tag;
  assign out_free   = !r_if.rvalid || r_if.rready;
  assign last_beat  = (cnt == 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state    = state;
    cpl_hdr_rden  = 1'b0;
    cpl_data_rden = 1'b0;
    load          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!cpl_hdr_empty && !rst) begin
          cpl_hdr_rden = 1'b1;
          next_state   = (hdr.status == CPL_SC) ? ST_DATA : ST_ERR;
        end
      end
      ST_DATA: begin
        if (out_free && !settle && !cpl_data_empty) begin
          load          = 1'b1;
          cpl_data_rden = 1'b1;
          if (last_beat)
            next_state = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (out_free && !settle) begin
          load = 1'b1;
          if (last_beat)
            next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // settle holds off the first load one cycle after a header pop so rvalid lands at pop+2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= 8'd0;
      cpl_id      <= '0;
      settle      <= 1'b0;
      r_if.rvalid <= 1'b0;
      r_if.rlast  <= 1'b0;
      r_if.rresp  <= 2'b00;
      r_if.rdata  <= '0;
      r_if.rid    <= '0;
    end else begin
      settle <= cpl_hdr_rden;
      if (cpl_hdr_rden) begin
        cnt    <= (hdr.status == CPL_SC) ? data_beats(hdr.length) : err_beats(hdr.byte_count);
        cpl_id <= hdr.tag[ID_WIDTH-1:0];
      end else if (load) begin
        cnt <= cnt - 8'd1;
      end

      if (load) begin
        r_if.rvalid <= 1'b1;
        r_if.rlast  <= last_beat;
        r_if.rid    <= cpl_id;
        r_if.rdata  <= (state == ST_DATA) ? cpl_data_data : '0;
        r_if.rresp  <= (state == ST_DATA) ? RRESP_OKAY : RRESP_SLVERR;
      end else if (r_if.rready) begin
        r_if.rvalid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
